// File: rtl/mmio_io_responder.sv
// MMIO target for the 0xFFFFFC00-0xFFFFFFFF window: LEDs, switches, button flag, cycle counter, 7-seg data.
// Define MMIO_BUS_ERR_EN to add the sticky bus-error register at 0x014 and the bus_err output.
`timescale 1ns/1ps

module mmio_io_responder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SW_W            = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            IORead,
  input  logic            IOWrite,
  input  logic [9:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [SW_W-1:0] sw_raw,
  input  logic            btn_raw,
  output logic [SW_W-1:0] led,
  output logic [31:0]     seg_data
`ifdef MMIO_BUS_ERR_EN
  ,
  output logic            bus_err
`endif
);

  localparam int NIN = SW_W + 1;
  localparam int CW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [7:0] OFF_LED = 8'h00;
  localparam logic [7:0] OFF_SW  = 8'h01;
  localparam logic [7:0] OFF_BTN = 8'h02;
  localparam logic [7:0] OFF_CYC = 8'h03;
  localparam logic [7:0] OFF_SEG = 8'h04;
`ifdef MMIO_BUS_ERR_EN
  localparam logic [7:0] OFF_ERR = 8'h05;
`endif

  logic [7:0]      off;
  logic            addr_unused;
  logic [NIN-1:0]  inRaw;
  logic [NIN-1:0]  sync1_q, sync2_q;
  logic [NIN-1:0]  deb_q, deb_d;
  logic [CW-1:0]   cnt_q [NIN];
  logic [CW-1:0]   cnt_d [NIN];
  logic [SW_W-1:0] led_q, led_d;
  logic [31:0]     seg_q, seg_d;
  logic [31:0]     cyc_q, cyc_d;
  logic            flag_q, flag_d;
  logic            btnRise;

  assign off         = addr[9:2];
  assign addr_unused = ^addr[1:0];
  assign inRaw       = {btn_raw, sw_raw};

  // Per-input debounce: the counter only runs while the synchronized value disagrees with the debounced one.
  always_comb begin
    for (int i = 0; i < NIN; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign btnRise = deb_d[SW_W] & ~deb_q[SW_W];

  always_comb begin
    led_d  = led_q;
    seg_d  = seg_q;
    cyc_d  = cyc_q + 32'd1;
    flag_d = flag_q;
    if (IOWrite && off == OFF_LED) led_d = wdata[SW_W-1:0];
    if (IOWrite && off == OFF_SEG) seg_d = wdata;
    if (IOWrite && off == OFF_CYC) cyc_d = wdata;
    // A press edge landing on the clearing read wins.
    if (btnRise) begin
      flag_d = 1'b1;
    end else if (IORead && off == OFF_BTN) begin
      flag_d = 1'b0;
    end
  end

`ifdef MMIO_BUS_ERR_EN
  logic [1:0] err_q, err_d;
  logic       unmapped;
  logic       roWrite;

  assign unmapped = (IORead || IOWrite) && (off > OFF_ERR);
  assign roWrite  = IOWrite && (off == OFF_SW || off == OFF_BTN);

  always_comb begin
    err_d = err_q;
    if (IORead && off == OFF_ERR) err_d = 2'b00;
    err_d = err_d | {roWrite, unmapped};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 2'b00;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus_err = |err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '{default: '0};
      led_q   <= '0;
      seg_q   <= '0;
      cyc_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      sync1_q <= inRaw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      seg_q   <= seg_d;
      cyc_q   <= cyc_d;
      flag_q  <= flag_d;
    end
  end

  // Read mux reflects registered state only, so a simultaneous write shows the pre-write value.
  always_comb begin
    rdata = '0;
    if (IORead) begin
      case (off)
        OFF_LED: rdata = 32'(led_q);
        OFF_SW:  rdata = 32'(deb_q[SW_W-1:0]);
        OFF_BTN: rdata = {31'd0, flag_q};
        OFF_CYC: rdata = cyc_q;
        OFF_SEG: rdata = seg_q;
`ifdef MMIO_BUS_ERR_EN
        OFF_ERR: rdata = {30'd0, err_q};
`endif
        default: rdata = '0;
      endcase
    end
  end

  assign led      = led_q;
  assign seg_data = seg_q;

endmodule

// File: tb/tb_mmio_io_responder.sv
// Scoreboard bench for mmio_io_responder: reads push expected data from a window-based reference model.
// Covers the MMIO_BUS_ERR_EN build when that macro is defined.
`timescale 1ns/1ps

module tb_mmio_io_responder;

  localparam int DEB  = 8;
  localparam int SW_W = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            IORead = 1'b0;
  logic            IOWrite = 1'b0;
  logic [9:0]      addr = '0;
  logic [31:0]     wdata = '0;
  logic [31:0]     rdata;
  logic [SW_W-1:0] sw_raw = '0;
  logic            btn_raw = 1'b0;
  logic [SW_W-1:0] led;
  logic [31:0]     seg_data;
`ifdef MMIO_BUS_ERR_EN
  logic            bus_err;
`endif

  int nChecks = 0;
  int nFails  = 0;

  logic [31:0] expQ[$];

  // Reference model state, updated at each rising edge
  logic [SW_W-1:0] mLed, mSw;
  logic [31:0]     mSeg, mCyc;
  logic            mFlag, mBtn;
  logic [1:0]      mErr;
  logic [SW_W:0]   rawHist [10];

  mmio_io_responder #(.DEBOUNCE_CYCLES(DEB), .SW_W(SW_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .IORead   (IORead),
    .IOWrite  (IOWrite),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .sw_raw   (sw_raw),
    .btn_raw  (btn_raw),
    .led      (led),
    .seg_data (seg_data)
`ifdef MMIO_BUS_ERR_EN
    ,
    .bus_err  (bus_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [9:0] a);
    case (a & 10'h3FC)
      10'h000: return {16'd0, mLed};
      10'h004: return {16'd0, mSw};
      10'h008: return {31'd0, mFlag};
      10'h00C: return mCyc;
      10'h010: return mSeg;
`ifdef MMIO_BUS_ERR_EN
      10'h014: return {30'd0, mErr};
`endif
      default: return 32'd0;
    endcase
  endfunction

  // A debounced bit flips once the last eight synchronized samples (raw delayed by two edges) all disagree with it.
  always @(posedge clk) begin : refModel
    logic [SW_W:0] deb, newDeb;
    logic [9:0]    off;
    logic [1:0]    ev;
    bit            allDiff;
    if (!rst_n) begin
      mLed = '0; mSw = '0; mSeg = '0; mCyc = '0;
      mFlag = 1'b0; mBtn = 1'b0; mErr = 2'b00;
      for (int i = 0; i < 10; i++) rawHist[i] = '0;
    end else begin
      off = addr & 10'h3FC;
      deb = {mBtn, mSw};
      for (int i = 9; i > 0; i--) rawHist[i] = rawHist[i-1];
      rawHist[0] = {btn_raw, sw_raw};
      for (int b = 0; b <= SW_W; b++) begin
        allDiff = 1'b1;
        for (int j = 2; j <= 9; j++) if (rawHist[j][b] == deb[b]) allDiff = 1'b0;
        newDeb[b] = allDiff ? ~deb[b] : deb[b];
      end
      if (newDeb[SW_W] && !mBtn) mFlag = 1'b1;
      else if (IORead && off == 10'h008) mFlag = 1'b0;
      mSw  = newDeb[SW_W-1:0];
      mBtn = newDeb[SW_W];
      if (IOWrite && off == 10'h00C) mCyc = wdata;
      else mCyc = mCyc + 32'd1;
      if (IOWrite && off == 10'h000) mLed = wdata[SW_W-1:0];
      if (IOWrite && off == 10'h010) mSeg = wdata;
      ev[0] = (IORead || IOWrite) && off > 10'h014;
      ev[1] = IOWrite && (off == 10'h004 || off == 10'h008);
      if (IORead && off == 10'h014) mErr = ev;
      else mErr = mErr | ev;
    end
  end

  // Monitor: pops one expectation per read cycle, checks idle rdata and register outputs every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("reset_led", {16'd0, led}, 32'd0);
      checkOutput("reset_seg", seg_data, 32'd0);
      checkOutput("reset_rdata", rdata, 32'd0);
`ifdef MMIO_BUS_ERR_EN
      checkOutput("reset_bus_err", {31'd0, bus_err}, 32'd0);
`endif
    end else begin
      if (IORead) begin
        if (expQ.size() == 0) checkOutput("rdata_unexpected", rdata, 32'hXXXXXXXX);
        else checkOutput("rdata", rdata, expQ.pop_front());
      end else begin
        checkOutput("idle_rdata", rdata, 32'd0);
      end
      checkOutput("led", {16'd0, led}, {16'd0, mLed});
      checkOutput("seg_data", seg_data, mSeg);
`ifdef MMIO_BUS_ERR_EN
      checkOutput("bus_err", {31'd0, bus_err}, {31'd0, |mErr});
`endif
    end
  end

  task automatic applyStimulus(input bit rd, input bit wr, input logic [9:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    IORead  = rd;
    IOWrite = wr;
    addr    = a;
    wdata   = d;
    if (rd) expQ.push_back(modelRead(a));
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 10'($urandom), $urandom);
  endtask

  logic [9:0] addrPool [8] = '{10'h000, 10'h004, 10'h008, 10'h00C, 10'h010, 10'h014, 10'h020, 10'h3FC};

  initial begin
    $display("[TB] starting mmio_io_responder bench");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Load registers, then reset mid-run
    applyStimulus(1'b0, 1'b1, 10'h000, 32'h0000_1234);
    applyStimulus(1'b0, 1'b1, 10'h010, 32'hCAFE_F00D);
    idle(1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    IORead = 1'b0; IOWrite = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // LED write and readback
    applyStimulus(1'b0, 1'b1, 10'h000, 32'h0001_A5A5);
    applyStimulus(1'b1, 1'b0, 10'h000, 32'd0);
    idle(2);

    // Switch debounce, then a short glitch that must not propagate
    sw_raw = 16'h00F0;
    repeat (14) applyStimulus(1'b1, 1'b0, 10'h004, 32'd0);
    sw_raw = 16'hFFFF;
    repeat (5) applyStimulus(1'b1, 1'b0, 10'h004, 32'd0);
    sw_raw = 16'h00F0;
    repeat (12) applyStimulus(1'b1, 1'b0, 10'h006, 32'd0);

    // Long press, then read-to-clear
    btn_raw = 1'b1;
    idle(12);
    applyStimulus(1'b1, 1'b0, 10'h008, 32'd0);
    applyStimulus(1'b1, 1'b0, 10'h008, 32'd0);
    btn_raw = 1'b0;
    idle(12);
    applyStimulus(1'b1, 1'b0, 10'h008, 32'd0);

    // Press edge lands on the same edge as a clearing read
    btn_raw = 1'b1;
    idle(8);
    applyStimulus(1'b1, 1'b0, 10'h008, 32'd0);
    applyStimulus(1'b1, 1'b0, 10'h008, 32'd0);
    btn_raw = 1'b0;
    idle(12);

    // Cycle counter wrap
    applyStimulus(1'b0, 1'b1, 10'h00C, 32'hFFFF_FFFE);
    repeat (3) applyStimulus(1'b1, 1'b0, 10'h00C, 32'd0);

    // Unmapped and read-only accesses
    applyStimulus(1'b0, 1'b1, 10'h020, 32'h0000_DEAD);
    applyStimulus(1'b0, 1'b1, 10'h004, 32'h0000_1234);
    applyStimulus(1'b0, 1'b1, 10'h008, 32'h0000_0001);
    applyStimulus(1'b1, 1'b0, 10'h020, 32'd0);
    applyStimulus(1'b1, 1'b0, 10'h004, 32'd0);
    applyStimulus(1'b1, 1'b0, 10'h000, 32'd0);
    applyStimulus(1'b1, 1'b0, 10'h014, 32'd0);
    applyStimulus(1'b1, 1'b0, 10'h014, 32'd0);

    // SEG write and idle with wandering address
    applyStimulus(1'b0, 1'b1, 10'h010, 32'h1234_5678);
    idle(10);

    // Randomized traffic, including simultaneous read+write and input noise
    for (int n = 0; n < 400; n++) begin
      int sel;
      logic [9:0] a;
      sel = $urandom_range(0, 7);
      a = addrPool[$urandom_range(0, 7)] | 10'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) sw_raw = 16'($urandom);
      if ($urandom_range(0, 19) == 0) btn_raw = ~btn_raw;
      case (sel)
        0, 1, 2: applyStimulus(1'b1, 1'b0, a, $urandom);
        3, 4:    applyStimulus(1'b0, 1'b1, a, $urandom);
        5:       applyStimulus(1'b1, 1'b1, a, $urandom);
        default: applyStimulus(1'b0, 1'b0, a, $urandom);
      endcase
    end

    idle(2);
    @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
